shiftn_rx: RTL and testbench

Serial-in, parallel-out receiver: collects N serial bits one per strobe, shifting them into a working register in a chosen direction, then presents the assembled word with a one-cycle valid pulse. It is the receiving end for a rotate/shift-based serialiser in the shift-and-rotate datapath, and reconstructs the word a left- or right-rotating transmitter shifts out. Frame control is a small FSM with a bit counter, held-output register and optional parity check.

---
 rtl/shiftn_rx.sv | 128 ++++++++++++
 tb/tb_shiftn_rx.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/shiftn_rx.sv
// Serial-in, parallel-out receiver: N bits per frame, shift direction latched at start.
// Optional trailing even-parity bit, enabled by defining SHIFTN_RX_PARITY_EN.
module shiftn_rx #(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         dir,
  input  logic         sin,
  input  logic         svalid,
  input  logic         abort,
  output logic [N-1:0] y,
  output logic         yvalid,
  output logic         busy,
  output logic         err
);

  localparam int unsigned CW = $clog2(N + 1);
  localparam logic [CW-1:0] LastCnt = CW'(N - 1);

  typedef enum logic [1:0] {StIdle, StShift, StParity, StDone} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [N-1:0]  sreg_q;
  logic [N-1:0]  sreg_shift;
  logic [N-1:0]  y_q;
  logic          dir_q;
  logic          last_bit;
`ifdef SHIFTN_RX_PARITY_EN
  logic          err_q;
`endif

  // dir 0: MSB-first, new bit enters bit 0; dir 1: LSB-first, new bit enters bit N-1
  assign sreg_shift = dir_q ? {sin, sreg_q[N-1:1]} : {sreg_q[N-2:0], sin};
  assign last_bit   = svalid && (cnt_q == LastCnt);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start) state_d = StShift;
      end
      StShift: begin
        if (abort) begin
          state_d = StIdle;
        end else if (last_bit) begin
`ifdef SHIFTN_RX_PARITY_EN
          state_d = StParity;
`else
          state_d = StDone;
`endif
        end
      end
      StParity: begin
        if (abort) begin
          state_d = StIdle;
        end else if (svalid) begin
          state_d = StDone;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath; Y and ERR load on the edge that enters StDone.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      sreg_q <= '0;
      dir_q  <= 1'b0;
      y_q    <= '0;
`ifdef SHIFTN_RX_PARITY_EN
      err_q  <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            cnt_q  <= '0;
            sreg_q <= '0;
            dir_q  <= dir;
          end
        end
        StShift: begin
          if (!abort && svalid) begin
            cnt_q  <= cnt_q + CW'(1);
            sreg_q <= sreg_shift;
`ifndef SHIFTN_RX_PARITY_EN
            if (last_bit) y_q <= sreg_shift;
`endif
          end
        end
        StParity: begin
`ifdef SHIFTN_RX_PARITY_EN
          if (!abort && svalid) begin
            y_q   <= sreg_q;
            err_q <= sin ^ (^sreg_q);
          end
`endif
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy   = (state_q != StIdle);
    yvalid = (state_q == StDone);
    y      = y_q;
`ifdef SHIFTN_RX_PARITY_EN
    err    = err_q;
`else
    err    = 1'b0;
`endif
  end

endmodule

// File: tb/tb_shiftn_rx.sv
// Scoreboard bench for shiftn_rx: stimulus pushes expected words and YVALID cycles,
// a negedge monitor pops and compares whenever YVALID is seen.
module tb_shiftn_rx;

  localparam int unsigned N = 8;
`ifdef SHIFTN_RX_PARITY_EN
  localparam int unsigned PBits = 1;
`else
  localparam int unsigned PBits = 0;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         dir = 1'b0;
  logic         sin = 1'b0;
  logic         svalid = 1'b0;
  logic         abort = 1'b0;
  logic [N-1:0] y;
  logic         yvalid;
  logic         busy;
  logic         err;

  typedef struct {
    logic [7:0]  y;
    logic        err;
    int unsigned cyc;
  } exp_t;

  exp_t        sbq[$];
  int unsigned cyc = 0;
  int          n_total = 0;
  int          n_pass = 0;

  shiftn_rx #(.N(N)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .dir    (dir),
    .sin    (sin),
    .svalid (svalid),
    .abort  (abort),
    .y      (y),
    .yvalid (yvalid),
    .busy   (busy),
    .err    (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every YVALID must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (yvalid) begin
      if (sbq.size() == 0) begin
        check("unexpected_yvalid", 32'(yvalid), 32'd0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("y", 32'(y), 32'(e.y));
        check("err", 32'(err), 32'(e.err));
        check("yvalid_cycle", cyc, e.cyc);
      end
    end
  end

  // Full frame; seq[7] is sent first. stall_len idle cycles are inserted before bit index stall_at.
  task automatic frame(input logic d, input logic [7:0] seq, input logic [7:0] exp_y,
                       input logic pbit, input logic exp_err, input int stall_at,
                       input int stall_len, input logic toggle);
    exp_t e;
    start = 1'b1;
    dir   = d;
    e.y   = exp_y;
    e.err = (PBits != 0) ? exp_err : 1'b0;
    e.cyc = cyc + N + 1 + PBits + stall_len;
    sbq.push_back(e);
    step();
    start = 1'b0;
    check("busy_rise", 32'(busy), 32'd1);
    for (int i = 0; i < 8; i++) begin
      if (i == stall_at) begin
        for (int k = 0; k < stall_len; k++) begin
          svalid = 1'b0;
          if (toggle) dir = ~dir;
          step();
        end
      end
      svalid = 1'b1;
      sin    = seq[7-i];
      step();
    end
    if (PBits != 0) begin
      svalid = 1'b1;
      sin    = pbit;
      step();
    end
    svalid = 1'b0;
    step();
    check("busy_fall", 32'(busy), 32'd0);
  endtask

  initial begin
    step();
    step();
    check("rst_y", 32'(y), 32'd0);
    check("rst_yvalid", 32'(yvalid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    reset = 1'b0;
    step();

    // MSB-first, LSB-first, and stalled with DIR toggled mid-frame
    frame(1'b0, 8'b10101100, 8'b10101100, 1'b0, 1'b0, 99, 0, 1'b0);
    frame(1'b1, 8'b10101100, 8'b00110101, 1'b0, 1'b0, 99, 0, 1'b0);
    frame(1'b0, 8'b10101100, 8'b10101100, 1'b0, 1'b0, 4, 3, 1'b1);

    // Second START mid-frame, then ABORT after 5 bits
    start = 1'b1;
    dir   = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      svalid = 1'b1;
      sin    = 1'b1;
      start  = (i == 2);
      dir    = 1'b0;
      step();
    end
    start  = 1'b0;
    abort  = 1'b1;
    svalid = 1'b1;
    step();
    abort  = 1'b0;
    svalid = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_y_hold", 32'(y), 32'hAC);
    step();
    frame(1'b0, 8'hFF, 8'hFF, 1'b0, 1'b0, 99, 0, 1'b0);

    // Reset after 3 bits
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      svalid = 1'b1;
      sin    = 1'b1;
      step();
    end
    svalid = 1'b0;
    reset  = 1'b1;
    step();
    check("midrst_y", 32'(y), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_yvalid", 32'(yvalid), 32'd0);
    reset = 1'b0;
    step();
    frame(1'b0, 8'h5A, 8'h5A, 1'b0, 1'b0, 99, 0, 1'b0);

    // Parity: the data has even weight, so parity bit 1 is an error
    frame(1'b0, 8'b10101100, 8'b10101100, 1'b0, 1'b0, 99, 0, 1'b0);
    frame(1'b0, 8'b10101100, 8'b10101100, 1'b1, 1'b1, 99, 0, 1'b0);
    check("err_hold", 32'(err), 32'(PBits));

    repeat (4) step();
    check("sb_drained", sbq.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
